flip_counter: RTL and testbench

FLIP_COUNTER -- requirements
Module: flip_counter

---
 rtl/flip_counter.sv | 82 ++++++++
 tb/tb_flip_counter.sv | 119 +++++++++++
 2 files changed

// File: rtl/flip_counter.sv
// 4-bit synchronous binary up-counter built from four toggle flip-flops.
// Asynchronous active-high reset clears every stage to zero, independent of cp.

module flip_counter_tff (
  input  logic cp,
  input  logic rst,
  input  logic t_i,
  output logic q_o
);

  logic q_q;
  logic q_d;

  // Next state: invert when the toggle enable is high, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (t_i) begin
      q_d = ~q_q;
    end else begin
      q_d = q_q;
    end
  end

  // State flop with asynchronous clear.
  always_ff @(posedge cp or posedge rst) begin
    if (rst) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

module flip_counter (
  input  logic cp,
  input  logic rst,
  output logic out0,
  output logic out1,
  output logic out2,
  output logic out3
);

  logic [3:0] count_q;
  logic [3:0] toggle_d;

  // Stage n toggles only when every lower stage is 1, so all bits move on one edge.
  function automatic logic [3:0] toggle_enables(input logic [3:0] cnt);
    logic [3:0] t;
    t[0] = 1'b1;
    t[1] = cnt[0];
    t[2] = cnt[0] & cnt[1];
    t[3] = cnt[0] & cnt[1] & cnt[2];
    return t;
  endfunction

  // Toggle enables derived from the current registered count.
  always_comb begin
    toggle_d = 4'b0000;
    toggle_d = toggle_enables(count_q);
  end

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_stage
      flip_counter_tff u_tff (
        .cp  (cp),
        .rst (rst),
        .t_i (toggle_d[g]),
        .q_o (count_q[g])
      );
    end
  endgenerate

  assign out0 = count_q[0];
  assign out1 = count_q[1];
  assign out2 = count_q[2];
  assign out3 = count_q[3];

endmodule

// File: tb/tb_flip_counter.sv
// Directed self-checking bench for flip_counter: reset, counting, wrap,
// mid-count reset, reset held over edges, and stability on falling edges.

module tb_flip_counter;

  logic cp;
  logic rst;
  logic out0;
  logic out1;
  logic out2;
  logic out3;

  int passed;
  int total;
  int fails;

  flip_counter dut (
    .cp   (cp),
    .rst  (rst),
    .out0 (out0),
    .out1 (out1),
    .out2 (out2),
    .out3 (out3)
  );

  function automatic logic [3:0] count_now();
    return {out3, out2, out1, out0};
  endfunction

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // One 20 ns clock period: rising edge, check, falling edge, check unchanged.
  task automatic tick(input string tag, input logic [3:0] exp);
    logic [3:0] before_fall;
    cp = 1'b1;
    #1;
    check(tag, count_now(), exp);
    #9;
    before_fall = count_now();
    cp = 1'b0;
    #1;
    check({tag, "_fall"}, count_now(), before_fall);
    #9;
  endtask

  initial begin
    logic [3:0] exp;
    passed = 0;
    total  = 0;
    fails  = 0;
    cp  = 1'b0;
    rst = 1'b0;

    // Reset with cp idle takes effect immediately.
    #5;
    rst = 1'b1;
    #1;
    check("reset_idle", count_now(), 4'b0000);
    #4;
    rst = 1'b0;
    #10;

    // Ten edges, each incrementing by one.
    for (int i = 1; i <= 10; i++) begin
      exp = 4'(i);
      tick($sformatf("count_%0d", i), exp);
    end
    check("count_ten", count_now(), 4'b1010);

    // Full wrap from reset.
    rst = 1'b1;
    #1;
    check("reset_before_wrap", count_now(), 4'b0000);
    #2;
    rst = 1'b0;
    #7;
    for (int i = 1; i <= 16; i++) begin
      exp = 4'(i % 16);
      tick($sformatf("wrap_%0d", i), exp);
      if (i == 15) begin
        check("wrap_all_ones", count_now(), 4'b1111);
      end
    end
    check("wrap_zero", count_now(), 4'b0000);

    // Count to 0101, then reset while cp is low.
    for (int i = 1; i <= 5; i++) begin
      exp = 4'(i);
      tick($sformatf("pre_rst_%0d", i), exp);
    end
    check("at_0101", count_now(), 4'b0101);
    #3;
    rst = 1'b1;
    #1;
    check("mid_cycle_reset", count_now(), 4'b0000);
    #6;
    for (int i = 1; i <= 3; i++) begin
      tick($sformatf("rst_held_%0d", i), 4'b0000);
    end

    // Release between edges; first edge gives 0001.
    #5;
    rst = 1'b0;
    #5;
    tick("after_release", 4'b0001);
    tick("after_release_2", 4'b0010);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
